// File: rtl/mdio_pkg.sv
// Shared constants and types for the clause-22 MDIO responder.
// Opcodes, field widths and the frame-decoder state encoding.
package mdio_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int PRE_W  = 6;
  localparam int BIT_W  = 5;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  typedef enum logic [3:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA_RD,
    RDATA,
    TA_WR,
    WDATA
  } mdio_state_e;

endpackage

// File: rtl/mdio_phy_resp_if.sv
// Management bus seen by the responder: MDIO pad pair plus register-bank port.
// slave = the responder, master = MDIO master / register bank side.
interface mdio_phy_resp_if;
  import mdio_pkg::*;

  logic              mdc;
  logic              mdio_i;
  logic              mdio_o;
  logic              mdio_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_rd_en;
  logic [DATA_W-1:0] reg_rd_data;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  mdc, mdio_i, reg_rd_data,
    output mdio_o, mdio_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, frame_err
  );

  modport master (
    output mdc, mdio_i, reg_rd_data,
    input  mdio_o, mdio_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, frame_err
  );

endinterface

// File: rtl/mdio_edge_sync.sv
// Brings MDC/MDIO into the clk domain and flags each MDC rising edge.
// rise_o is a one-cycle pulse aligned with the matching synchronised MDIO bit.
module mdio_edge_sync (
  input  logic clk,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic rise_o,
  output logic mdio_s_o
);

  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  // NOTE: synchroniser flops carry no reset; they flush within two cycles and a
  // reset value could otherwise fabricate an MDC edge when reset is released.
  always_ff @(posedge clk) begin
    mdc_q  <= {mdc_q[1:0], mdc_i};
    mdio_q <= {mdio_q[0], mdio_i};
  end

  assign rise_o   = mdc_q[1] & ~mdc_q[2];
  assign mdio_s_o = mdio_q[1];

endmodule

// File: rtl/mdio_phy_resp.sv
// Clause-22 MDIO responder: decodes frames bit-by-bit on synchronised MDC rises,
// answers reads to PHY_ADDR and exports writes as single-cycle strobes.
module mdio_phy_resp
  import mdio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PHY_ADDR = 5'b00100,
  parameter int                PRE_MIN  = 32,
  parameter int                TIMEOUT  = 1024
) (
  input logic            clk,
  input logic            rst,
  mdio_phy_resp_if.slave bus
);

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [PRE_W-1:0]  PRE_SAT  = PRE_W'(PRE_MIN);

  logic rise;
  logic mdio_s;

  mdio_edge_sync u_sync (
    .clk      (clk),
    .mdc_i    (bus.mdc),
    .mdio_i   (bus.mdio_i),
    .rise_o   (rise),
    .mdio_s_o (mdio_s)
  );

  mdio_state_e       state_q,   state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [TMO_W-1:0]  tmo_q,     tmo_d;
  logic              is_rd_q,   is_rd_d;
  logic              mdio_o_q,  mdio_o_d;
  logic              mdio_oe_q, mdio_oe_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q,   wr_en_d;
  logic              rd_en_q,   rd_en_d;
  logic              err_q,     err_d;
  logic              rd_cap_q;
  logic              busy_q;

  // NOTE: every _d takes its hold value first so no branch can leave a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pre_cnt_d  = pre_cnt_q;
    tmo_d      = tmo_q;
    is_rd_d    = is_rd_q;
    mdio_o_d   = mdio_o_q;
    mdio_oe_d  = mdio_oe_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    err_d      = 1'b0;

    // Read data is taken one cycle after the request, well before the first TA rise.
    if (rd_cap_q) shift_d = bus.reg_rd_data;

    if (state_q == IDLE || rise) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d     = '0;
      err_d     = 1'b1;
      mdio_oe_d = 1'b0;
      mdio_o_d  = 1'b1;
      state_d   = IDLE;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (rise) begin
      unique case (state_q)
        IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q < PRE_SAT) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            if (pre_cnt_q >= PRE_SAT) state_d = ST;
            pre_cnt_d = '0;
          end
        end
        ST: begin
          bit_cnt_d = '0;
          if (mdio_s) state_d = OP;
          else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        OP: begin
          shift_d = {shift_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'd0) bit_cnt_d = 5'd1;
          else begin
            bit_cnt_d = '0;
            unique case (shift_d[1:0])
              OP_RD: begin is_rd_d = 1'b1; state_d = PHYAD; end
              OP_WR: begin is_rd_d = 1'b0; state_d = PHYAD; end
              default: begin err_d = 1'b1; state_d = IDLE; end
            endcase
          end
        end
        PHYAD: begin
          shift_d = {shift_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = '0;
            state_d   = (shift_d[ADDR_W-1:0] == PHY_ADDR) ? REGAD : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        REGAD: begin
          shift_d = {shift_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d  = '0;
            reg_addr_d = shift_d[ADDR_W-1:0];
            rd_en_d    = is_rd_q;
            state_d    = is_rd_q ? TA_RD : TA_WR;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        TA_RD: begin
          if (bit_cnt_q == 5'd0) begin
            mdio_oe_d = 1'b1;
            mdio_o_d  = 1'b0;
            bit_cnt_d = 5'd1;
          end else begin
            mdio_o_d  = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = '0;
            state_d   = RDATA;
          end
        end
        RDATA: begin
          // D15 went out from TA_RD; 15 shifts follow, then one more rise releases the pad.
          if (bit_cnt_q == 5'd15) begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            mdio_o_d  = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        TA_WR: begin
          if (mdio_s != (bit_cnt_q == 5'd0)) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = '0;
            state_d   = WDATA;
          end
        end
        WDATA: begin
          shift_d = {shift_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'd15) begin
            wr_data_d = shift_d;
            wr_en_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pre_cnt_q  <= '0;
      tmo_q      <= '0;
      is_rd_q    <= 1'b0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_cap_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pre_cnt_q  <= pre_cnt_d;
      tmo_q      <= tmo_d;
      is_rd_q    <= is_rd_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      err_q      <= err_d;
      rd_cap_q   <= rd_en_q;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.mdio_o      = mdio_o_q;
  assign bus.mdio_oe     = mdio_oe_q;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign bus.busy        = busy_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_mdio_phy_resp.sv
// Directed bench for mdio_phy_resp: an MDIO master model clocks frames at clk/8
// and each scenario task compares the responder's outputs with hand-derived values.
module tb_mdio_phy_resp;
  import mdio_pkg::*;

  localparam logic [4:0] PHY = 5'b00100;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  mdio_phy_resp_if bus ();

  mdio_phy_resp #(
    .PHY_ADDR (PHY),
    .PRE_MIN  (32),
    .TIMEOUT  (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running tallies of output activity; scenarios compare deltas around a frame.
  int         wr_cyc = 0;
  int         rd_cyc = 0;
  int         err_cyc = 0;
  int         oe_cyc = 0;
  logic [4:0] wr_addr_seen = '0;
  logic [4:0] rd_addr_seen = '0;
  logic [15:0] wr_data_seen = '0;

  always @(negedge clk) begin
    if (bus.reg_wr_en) begin
      wr_cyc++;
      wr_addr_seen = bus.reg_addr;
      wr_data_seen = bus.reg_wr_data;
    end
    if (bus.reg_rd_en) begin
      rd_cyc++;
      rd_addr_seen = bus.reg_addr;
    end
    if (bus.frame_err) err_cyc++;
    if (bus.mdio_oe) oe_cyc++;
  end

  // One MDC period: 4 clk low with data set up, then 4 clk high; line sampled at the rise.
  task automatic mdc_cycle(input logic b, output logic sampled);
    @(negedge clk);
    bus.mdc    = 1'b0;
    bus.mdio_i = b;
    repeat (4) @(negedge clk);
    sampled = bus.mdio_oe ? bus.mdio_o : 1'b1;
    bus.mdc = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.mdio_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int pre_n, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad, input logic [15:0] wdata, input int n_bits,
                            output logic [16:0] line, output logic busy_hdr);
    logic [31:0] fr;
    logic        s;
    if (op == OP_RD) fr = {2'b01, op, phy, regad, 2'b11, 16'hFFFF};
    else             fr = {2'b01, op, phy, regad, 2'b10, wdata};
    line     = '1;
    busy_hdr = 1'b0;
    for (int i = 0; i < pre_n; i++) mdc_cycle(1'b1, s);
    for (int i = 31; i > 31 - n_bits; i--) begin
      mdc_cycle(fr[i], s);
      if (i <= 16) line[i] = s;
      if (i == 18) busy_hdr = bus.busy;
    end
  endtask

  task automatic test_reset();
    logic [26:0] got;
    rst             = 1'b1;
    bus.mdc         = 1'b1;
    bus.mdio_i      = 1'b1;
    bus.reg_rd_data = '0;
    repeat (5) @(negedge clk);
    got = {bus.mdio_oe, bus.mdio_o, bus.reg_wr_en, bus.reg_rd_en, bus.reg_addr,
           bus.reg_wr_data, bus.busy, bus.frame_err};
    n_total++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0})
      $display("FAIL reset_outputs got=%b want=%b", got,
               {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0});
    else n_pass++;
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_write();
    int w0, e0, o0;
    logic [16:0] line;
    logic bh;
    w0 = wr_cyc; e0 = err_cyc; o0 = oe_cyc;
    send_frame(32, OP_WR, PHY, 5'd0, 16'h1140, 32, line, bh);
    idle(8);
    n_total++;
    if (wr_cyc - w0 !== 1) $display("FAIL wr_strobe_cycles got=%0d want=1", wr_cyc - w0);
    else n_pass++;
    n_total++;
    if (wr_addr_seen !== 5'd0) $display("FAIL wr_addr got=%0d want=0", wr_addr_seen);
    else n_pass++;
    n_total++;
    if (wr_data_seen !== 16'h1140) $display("FAIL wr_data got=%h want=1140", wr_data_seen);
    else n_pass++;
    n_total++;
    if (oe_cyc - o0 !== 0) $display("FAIL wr_oe_cycles got=%0d want=0", oe_cyc - o0);
    else n_pass++;
    n_total++;
    if (bh !== 1'b1) $display("FAIL wr_busy_mid got=%b want=1", bh);
    else n_pass++;
    n_total++;
    if ({bus.busy, err_cyc - e0 == 0} !== 2'b01)
      $display("FAIL wr_end busy=%b errs=%0d want busy=0 errs=0", bus.busy, err_cyc - e0);
    else n_pass++;
  endtask

  task automatic test_read();
    int r0, w0, o0;
    logic [16:0] line;
    logic bh;
    r0 = rd_cyc; w0 = wr_cyc; o0 = oe_cyc;
    bus.reg_rd_data = 16'h796D;
    send_frame(32, OP_RD, PHY, 5'd1, 16'h0000, 32, line, bh);
    idle(8);
    n_total++;
    if (rd_cyc - r0 !== 1) $display("FAIL rd_strobe_cycles got=%0d want=1", rd_cyc - r0);
    else n_pass++;
    n_total++;
    if (rd_addr_seen !== 5'd1) $display("FAIL rd_addr got=%0d want=1", rd_addr_seen);
    else n_pass++;
    n_total++;
    if (oe_cyc - o0 !== 17 * 8) $display("FAIL rd_oe_cycles got=%0d want=136", oe_cyc - o0);
    else n_pass++;
    n_total++;
    if (line !== {1'b0, 16'h796D}) $display("FAIL rd_line got=%b want=%b", line, {1'b0, 16'h796D});
    else n_pass++;
    n_total++;
    if ({bus.mdio_oe, bus.busy, wr_cyc - w0 == 0} !== 3'b001)
      $display("FAIL rd_end oe=%b busy=%b writes=%0d want 0 0 0", bus.mdio_oe, bus.busy, wr_cyc - w0);
    else n_pass++;
  endtask

  task automatic test_phyad_mismatch();
    int r0, w0, e0, o0;
    logic [16:0] line;
    logic bh;
    r0 = rd_cyc; w0 = wr_cyc; e0 = err_cyc; o0 = oe_cyc;
    send_frame(32, OP_RD, 5'b00011, 5'd1, 16'h0000, 32, line, bh);
    idle(8);
    n_total++;
    if ({rd_cyc - r0, oe_cyc - o0, err_cyc - e0} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL mismatch_quiet rd=%0d oe=%0d err=%0d want 0 0 0", rd_cyc - r0, oe_cyc - o0, err_cyc - e0);
    else n_pass++;
    n_total++;
    if (bh !== 1'b0) $display("FAIL mismatch_busy got=%b want=0", bh);
    else n_pass++;
    send_frame(32, OP_WR, PHY, 5'd5, 16'hA5C3, 32, line, bh);
    idle(8);
    n_total++;
    if ({wr_cyc - w0, wr_addr_seen, wr_data_seen} !== {32'd1, 5'd5, 16'hA5C3})
      $display("FAIL after_mismatch_wr n=%0d addr=%0d data=%h want 1 5 a5c3", wr_cyc - w0, wr_addr_seen, wr_data_seen);
    else n_pass++;
  endtask

  task automatic test_preamble_and_op();
    int w0, r0, e0;
    logic [16:0] line;
    logic bh;
    w0 = wr_cyc; r0 = rd_cyc; e0 = err_cyc;
    send_frame(31, OP_WR, PHY, 5'd2, 16'h0000, 32, line, bh);
    idle(8);
    n_total++;
    if ({wr_cyc - w0, err_cyc - e0, bh} !== {32'd0, 32'd0, 1'b0})
      $display("FAIL short_preamble writes=%0d errs=%0d busy=%b want 0 0 0", wr_cyc - w0, err_cyc - e0, bh);
    else n_pass++;
    send_frame(32, 2'b11, PHY, 5'd2, 16'h0000, 4, line, bh);
    idle(8);
    n_total++;
    if (err_cyc - e0 !== 1) $display("FAIL op11_err_cycles got=%0d want=1", err_cyc - e0);
    else n_pass++;
    n_total++;
    if ({wr_cyc - w0, rd_cyc - r0, bus.busy} !== {32'd0, 32'd0, 1'b0})
      $display("FAIL op11_quiet writes=%0d reads=%0d busy=%b want 0 0 0", wr_cyc - w0, rd_cyc - r0, bus.busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    logic found;
    logic [16:0] line;
    logic bh;
    send_frame(32, OP_RD, PHY, 5'd7, 16'h0000, 14, line, bh);
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      found = bus.frame_err;
    end
    n_total++;
    if (!found) $display("FAIL timeout_err not seen within 200 cycles");
    else if (n !== 64) $display("FAIL timeout_latency got=%0d want=64", n);
    else n_pass++;
    n_total++;
    if ({bus.mdio_oe, bus.busy} !== 2'b00)
      $display("FAIL timeout_release oe=%b busy=%b want 0 0", bus.mdio_oe, bus.busy);
    else n_pass++;
    idle(8);
  endtask

  task automatic test_reset_mid_read();
    int w0;
    logic [26:0] got;
    logic [16:0] line;
    logic bh;
    bus.reg_rd_data = 16'h796D;
    send_frame(32, OP_RD, PHY, 5'd2, 16'h0000, 21, line, bh);
    n_total++;
    if ({bus.mdio_oe, bus.busy} !== 2'b11)
      $display("FAIL mid_read_drive oe=%b busy=%b want 1 1", bus.mdio_oe, bus.busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    got = {bus.mdio_oe, bus.mdio_o, bus.reg_wr_en, bus.reg_rd_en, bus.reg_addr,
           bus.reg_wr_data, bus.busy, bus.frame_err};
    n_total++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0})
      $display("FAIL mid_read_reset got=%b want=%b", got,
               {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0});
    else n_pass++;
    rst = 1'b0;
    idle(4);
    w0 = wr_cyc;
    send_frame(32, OP_WR, PHY, 5'd3, 16'hBEEF, 32, line, bh);
    idle(8);
    n_total++;
    if ({wr_cyc - w0, wr_addr_seen, wr_data_seen} !== {32'd1, 5'd3, 16'hBEEF})
      $display("FAIL post_reset_wr n=%0d addr=%0d data=%h want 1 3 beef", wr_cyc - w0, wr_addr_seen, wr_data_seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_phyad_mismatch();
    test_preamble_and_op();
    test_timeout();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
